// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared FSM state and FIFO entry types for the register-file write arbiter
package rf_write_arbiter_pkg;
    localparam int ADDR_MAX = 8;
    localparam int DATA_MAX = 64;
    typedef enum logic {NORMAL, DRAIN} state_t;
    typedef struct packed {
        logic                valid;
        logic [ADDR_MAX-1:0] addr;
        logic [DATA_MAX-1:0] data;
    } entry_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: secondary write FIFO with cancel-by-address and per-entry valid/addr export
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int N     = 5,
    parameter int M     = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [N-1:0]     push_addr,
    input  logic [M-1:0]     push_data,
    input  logic             pop,
    input  logic             cancel,
    input  logic [N-1:0]     cancel_addr,
    output entry_t           head,
    output logic             empty,
    output logic             full,
    output logic [DEPTH-1:0] ent_valid,
    output logic [N-1:0]     ent_addr [DEPTH]
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW-1:0] rd, wr;
    logic [CW-1:0] count;
    logic [M-1:0]  data [DEPTH];
    // cancel first, then pop clears its slot, then push writes the younger entry last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd        <= '0;
            wr        <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                data[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (cancel && ent_addr[i] == cancel_addr) ent_valid[i] <= 1'b0;
            if (pop) begin
                ent_valid[rd] <= 1'b0;
                rd            <= rd + 1'b1;
            end
            if (push) begin
                ent_valid[wr] <= 1'b1;
                ent_addr[wr]  <= push_addr;
                data[wr]      <= push_data;
                wr            <= wr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign head  = '{ent_valid[rd], ADDR_MAX'(ent_addr[rd]), DATA_MAX'(data[rd])};
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges primary and FIFO-buffered secondary writes onto one register-file write port
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int N        = 5,
    parameter int M        = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p_valid,
    input  logic [N-1:0]    p_addr,
    input  logic [M-1:0]    p_data,
    output logic            stall_o,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N-1:0]    s_addr,
    input  logic [M-1:0]    s_data,
    output logic            we,
    output logic [N-1:0]    a3,
    output logic [M-1:0]    wd3,
    output logic [2**N-1:0] pending_mask
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_t           state, state_n;
    logic [WW-1:0]    cnt, cnt_n;
    entry_t           head;
    logic             empty, full, p_acc, pop, push, h_we, unused_head;
    logic [DEPTH-1:0] ent_valid;
    logic [N-1:0]     ent_addr [DEPTH];
    assign p_acc       = state == NORMAL && p_valid && p_addr != '0;
    assign pop         = !empty && !p_acc;
    assign push        = s_valid && !full && s_addr != '0;
    assign s_ready     = !full;
    assign stall_o     = state == DRAIN;
    assign unused_head = ^head;
    rf_wr_fifo #(.N(N), .M(M), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .push_addr(s_addr), .push_data(s_data),
        .pop(pop), .cancel(p_acc), .cancel_addr(p_addr), .head(head), .empty(empty),
        .full(full), .ent_valid(ent_valid), .ent_addr(ent_addr)
    );
    always_comb begin
        h_we    = pop && head.valid;
        we      = p_acc || h_we;
        a3      = p_acc ? p_addr : h_we ? head.addr[N-1:0] : '0;
        wd3     = p_acc ? p_data : h_we ? head.data[M-1:0] : '0;
        cnt_n   = (empty || pop) ? '0 : cnt + 1'b1;
        state_n = state == DRAIN ? NORMAL : cnt_n == WW'(MAX_WAIT) ? DRAIN : NORMAL;
    end
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_valid[i]) pending_mask[ent_addr[i]] = 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors with hand-computed expectations for rf_write_arbiter
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_valid = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        stall_o;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pending_mask;
    logic        rf_clr = 1'b1;
    logic [31:0] rf [32];
    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.N(5), .M(32), .DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
        .stall_o(stall_o), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_data(s_data), .we(we), .a3(a3), .wd3(wd3), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we) begin
            rf[a3] <= wd3;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        #1;
    endtask

    initial begin
        step; step;
        reset = 1'b0; rf_clr = 1'b0;
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_we", we, 0);
        check("rst_pending", pending_mask, 0);

        // single secondary write, written back one cycle after the handshake
        drive(0, 0, 0, 1, 5, 32'hA5);
        check("sec_no_bypass", we, 0);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("sec_we", we, 1);
        check("sec_a3", a3, 5);
        check("sec_wd3", wd3, 32'hA5);
        check("sec_pending5", pending_mask, 32'h20);
        step;
        check("sec_done_we", we, 0);
        check("sec_done_pending", pending_mask, 0);

        // primary hogs the port; the FIFO head forces a one-cycle stall after four waits
        drive(1, 3, 32'h33, 1, 7, 32'h77);
        check("starve_p_a3", a3, 3);
        step;
        drive(1, 3, 32'h33, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check("starve_wait_stall", stall_o, 0);
            check("starve_wait_a3", a3, 3);
            check("starve_wait_pending", pending_mask, 32'h80);
            step;
        end
        check("starve_stall", stall_o, 1);
        check("starve_drain_we", we, 1);
        check("starve_drain_a3", a3, 7);
        check("starve_drain_wd3", wd3, 32'h77);
        step;
        check("starve_after_stall", stall_o, 0);
        check("starve_after_a3", a3, 3);
        check("starve_after_pending", pending_mask, 0);

        // full FIFO back-pressure and simultaneous push/pop
        drive(1, 3, 32'h33, 1, 10, 32'h10);
        step;
        drive(1, 3, 32'h33, 1, 11, 32'h11);
        step;
        drive(1, 3, 32'h33, 1, 12, 32'h12);
        check("full_s_ready", s_ready, 0);
        check("full_pending", pending_mask, 32'h0C00);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("full_pop_a3", a3, 10);
        check("full_pop_s_ready", s_ready, 0);
        step;
        drive(0, 0, 0, 1, 12, 32'h0C);
        check("pushpop_s_ready", s_ready, 1);
        check("pushpop_a3", a3, 11);
        step;
        drive(1, 3, 32'h33, 1, 13, 32'h0D);
        check("pushpop_count_kept", s_ready, 1);
        check("pushpop_pending", pending_mask, 32'h1000);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("refill_s_ready", s_ready, 0);
        check("refill_a3", a3, 12);
        check("refill_wd3", wd3, 32'h0C);
        step;
        check("refill2_a3", a3, 13);
        check("refill2_wd3", wd3, 32'h0D);
        step;
        check("refill_empty_we", we, 0);
        check("refill_empty_pending", pending_mask, 0);

        // a primary write cancels an older buffered write to the same register
        drive(1, 3, 32'h33, 1, 9, 32'h11);
        step;
        drive(1, 9, 32'h22, 0, 0, 0);
        check("cancel_p_a3", a3, 9);
        check("cancel_p_wd3", wd3, 32'h22);
        check("cancel_pending_before", pending_mask, 32'h200);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("cancel_pending_after", pending_mask, 0);
        check("cancel_pop_we", we, 0);
        check("cancel_pop_a3", a3, 0);
        check("cancel_pop_wd3", wd3, 0);
        step;
        check("cancel_rf9", rf[9], 32'h22);
        check("cancel_s_ready", s_ready, 1);

        // same-cycle secondary to the primary's register stays valid
        drive(1, 6, 32'h66, 1, 6, 32'h67);
        check("same_p_wd3", wd3, 32'h66);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("same_s_we", we, 1);
        check("same_s_a3", a3, 6);
        check("same_s_wd3", wd3, 32'h67);
        step;
        check("same_rf6", rf[6], 32'h67);

        // register zero is never written and never pending
        drive(1, 0, 32'hBAD, 1, 0, 32'hBAD);
        check("x0_we", we, 0);
        check("x0_s_ready", s_ready, 1);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("x0_not_enqueued", we, 0);
        check("x0_pending", pending_mask, 0);
        drive(0, 0, 0, 1, 4, 32'h44);
        step;
        drive(1, 0, 32'hBAD, 0, 0, 0);
        check("x0_port_free_we", we, 1);
        check("x0_port_free_a3", a3, 4);
        check("x0_port_free_wd3", wd3, 32'h44);
        step;
        drive(0, 0, 0, 0, 0, 0);
        check("x0_rf0", rf[0], 0);

        // reset while draining with two buffered entries
        drive(1, 3, 32'h33, 1, 20, 32'h20);
        step;
        drive(1, 3, 32'h33, 1, 21, 32'h21);
        step;
        drive(1, 3, 32'h33, 0, 0, 0);
        for (int k = 0; k < 10 && !stall_o; k++) step;
        check("rstmid_reached_drain", stall_o, 1);
        check("rstmid_pending", pending_mask, 32'h0030_0000);
        p_valid = 1'b0;
        reset = 1'b1;
        step;
        check("rstmid_stall", stall_o, 0);
        check("rstmid_s_ready", s_ready, 1);
        check("rstmid_we", we, 0);
        check("rstmid_pending_clr", pending_mask, 0);
        reset = 1'b0;
        step;
        check("rstmid_after_we", we, 0);
        check("rstmid_after_stall", stall_o, 0);
        check("rstmid_rf20", rf[20], 0);
        check("rstmid_rf21", rf[21], 0);
        check("final_rf0", rf[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
